// File: rtl/brick_field_ctrl.sv
// Brick wall alive-state owner: scans one brick per clock against a ball
// snapshot, clears and scores the first contact, reports it via valid/ack.
module brick_field_ctrl #(
  parameter int COLS     = 8,
  parameter int ROWS     = 4,
  parameter int B_WIDTH  = 30,
  parameter int B_HEIGHT = 5,
  parameter int MARGIN   = 10,
  parameter int X0       = 40,
  parameter int Y0       = 20,
  parameter int PITCH_X  = 70,
  parameter int PITCH_Y  = 20,
  parameter int POINTS   = 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_start,
  input  logic                           i_animate,
  input  logic                           i_ani_stb,
  input  logic [11:0]                    i_ball_x,
  input  logic [11:0]                    i_ball_y,
  input  logic                           i_hit_ack,
  output logic                           o_hit_valid,
  output logic [1:0]                     o_hit_type,
  output logic [$clog2(ROWS*COLS)-1:0]   o_hit_idx,
  output logic [ROWS*COLS-1:0]           o_alive,
  output logic [8:0]                     o_score,
  output logic                           o_endgame,
  output logic                           o_busy,
  output logic                           o_overrun
);
  localparam int N  = ROWS * COLS;
  localparam int IW = $clog2(N);
  localparam int E  = B_WIDTH + MARGIN;
  localparam int F  = B_HEIGHT + MARGIN;

  typedef enum logic [1:0] {
    S_IDLE, S_SCAN, S_HIT, S_DONE
  } state_t;

  state_t         r_state, w_next;
  logic [IW-1:0]  r_idx;
  logic [11:0]    r_bx, r_by;
  logic [N-1:0]   r_alive;
  logic [8:0]     r_score;
  logic [1:0]     r_type;
  logic [IW-1:0]  r_hidx;
  logic           r_overrun;

  logic [12:0] w_bx, w_by, w_cx, w_cy;
  logic [12:0] w_l, w_r, w_t, w_b, w_lo_x, w_lo_y;
  logic        w_l_ok, w_t_ok;
  logic        w_xe, w_ye, w_xin, w_yin;
  logic [1:0]  w_type;
  logic        w_hit, w_go;
  logic [9:0]  w_sum;

  assign w_bx = {1'b0, r_bx};
  assign w_by = {1'b0, r_by};
  assign w_cx = 13'(X0 + (int'(r_idx) % COLS) * PITCH_X);
  assign w_cy = 13'(Y0 + (int'(r_idx) / COLS) * PITCH_Y);

  // Edges that would fall below zero are flagged so they never match.
  assign w_l_ok = w_cx >= 13'(E);
  assign w_t_ok = w_cy >= 13'(F);
  assign w_l    = w_cx - 13'(E);
  assign w_r    = w_cx + 13'(E);
  assign w_t    = w_cy - 13'(F);
  assign w_b    = w_cy + 13'(F);
  assign w_lo_x = w_l_ok ? w_l : 13'd0;
  assign w_lo_y = w_t_ok ? w_t : 13'd0;

  assign w_xe  = (w_l_ok && w_bx == w_l) || w_bx == w_r;
  assign w_ye  = (w_t_ok && w_by == w_t) || w_by == w_b;
  assign w_xin = w_bx >= w_lo_x && w_bx <= w_r;
  assign w_yin = w_by >= w_lo_y && w_by <= w_b;

  always_comb begin
    w_type = 2'b00;
    if (w_xe && w_ye)       w_type = 2'b11;
    else if (w_ye && w_xin) w_type = 2'b01;
    else if (w_xe && w_yin) w_type = 2'b10;
  end

  assign w_hit = r_alive[r_idx] && (w_type != 2'b00);
  assign w_go  = i_ani_stb && i_animate;
  assign w_sum = {1'b0, r_score} + 10'(POINTS);

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_go) w_next = S_SCAN;
      S_SCAN: begin
        if (w_hit)                     w_next = S_HIT;
        else if (r_idx == IW'(N - 1))  w_next = S_IDLE;
      end
      S_HIT:  if (i_hit_ack)
                w_next = (r_alive == '0) ? S_DONE : S_IDLE;
      S_DONE: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (i_start) w_next = S_IDLE;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx     <= '0;
      r_bx      <= '0;
      r_by      <= '0;
      r_alive   <= '1;
      r_score   <= '0;
      r_type    <= '0;
      r_hidx    <= '0;
      r_overrun <= 1'b0;
    end else if (i_start) begin
      r_idx     <= '0;
      r_alive   <= '1;
      r_score   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (i_ani_stb && r_state != S_IDLE) r_overrun <= 1'b1;
      unique case (r_state)
        S_IDLE: if (w_go) begin
          r_bx  <= i_ball_x;
          r_by  <= i_ball_y;
          r_idx <= '0;
        end
        S_SCAN: begin
          if (w_hit) begin
            r_alive[r_idx] <= 1'b0;
            r_type         <= w_type;
            r_hidx         <= r_idx;
            r_score        <= w_sum[9] ? 9'd511 : w_sum[8:0];
          end else if (r_idx != IW'(N - 1)) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_hit_valid = r_state == S_HIT;
  assign o_hit_type  = r_type;
  assign o_hit_idx   = r_hidx;
  assign o_alive     = r_alive;
  assign o_score     = r_score;
  assign o_endgame   = r_state == S_DONE;
  assign o_busy      = r_state != S_IDLE;
  assign o_overrun   = r_overrun;
endmodule

// File: tb/tb_brick_field_ctrl.sv
// Randomized self-checking bench for brick_field_ctrl against a
// first-contact geometric reference model of the brick wall.
module tb_brick_field_ctrl;
  localparam int COLS = 8, ROWS = 4, N = 32;
  localparam int E = 40, F = 15;
  localparam int X0 = 40, Y0 = 20, PX = 70, PY = 20;

  logic        clk = 0, rst_n = 0;
  logic        i_start = 0, i_animate = 0, i_ani_stb = 0, i_hit_ack = 0;
  logic [11:0] i_ball_x = 0, i_ball_y = 0;
  logic        o_hit_valid, o_endgame, o_busy, o_overrun;
  logic [1:0]  o_hit_type;
  logic [4:0]  o_hit_idx;
  logic [31:0] o_alive;
  logic [8:0]  o_score;

  int tests_run = 0, fails = 0;
  logic [31:0] m_alive;
  int          m_score;
  logic        m_over;

  brick_field_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(i_start),
    .i_animate(i_animate), .i_ani_stb(i_ani_stb),
    .i_ball_x(i_ball_x), .i_ball_y(i_ball_y),
    .i_hit_ack(i_hit_ack), .o_hit_valid(o_hit_valid),
    .o_hit_type(o_hit_type), .o_hit_idx(o_hit_idx),
    .o_alive(o_alive), .o_score(o_score),
    .o_endgame(o_endgame), .o_busy(o_busy),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  function automatic int bcx(input int i);
    return X0 + (i % COLS) * PX;
  endfunction
  function automatic int bcy(input int i);
    return Y0 + (i / COLS) * PY;
  endfunction

  // First alive brick the ball touches, by absolute distance to its centre.
  function automatic void ref_hit(input int bx, input int by,
                                  output int idx, output logic [1:0] typ);
    idx = -1;
    typ = 2'b00;
    for (int i = 0; i < N; i++) begin
      int adx, ady;
      logic [1:0] t;
      adx = bx - bcx(i); if (adx < 0) adx = -adx;
      ady = by - bcy(i); if (ady < 0) ady = -ady;
      t = 2'b00;
      if (adx == E && ady == F)      t = 2'b11;
      else if (ady == F && adx <= E) t = 2'b01;
      else if (adx == E && ady <= F) t = 2'b10;
      if (idx < 0 && m_alive[i] && t != 2'b00) begin
        idx = i;
        typ = t;
      end
    end
  endfunction

  task automatic do_start();
    @(negedge clk);
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    m_alive = '1;
    m_score = 0;
    m_over  = 0;
  endtask

  task automatic do_ack();
    @(negedge clk);
    i_hit_ack = 1;
    @(negedge clk);
    i_hit_ack = 0;
  endtask

  task automatic run_frame(input int bx, input int by, output bit hit,
                           output int lat, output logic [1:0] typ,
                           output int idx);
    @(negedge clk);
    i_ball_x = 12'(bx);
    i_ball_y = 12'(by);
    i_animate = 1;
    i_ani_stb = 1;
    @(negedge clk);
    i_ani_stb = 0;
    i_ball_x = 12'($urandom_range(0, 700));
    i_ball_y = 12'($urandom_range(0, 200));
    lat = 1;
    while (!o_hit_valid && o_busy && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    hit = o_hit_valid;
    typ = o_hit_type;
    idx = int'(o_hit_idx);
  endtask

  // Runs a frame and checks it against the model; updates the model.
  task automatic frame_check(input string nm, input int bx, input int by);
    bit hit; int lat, idx, eidx, elat; logic [1:0] typ, etyp;
    ref_hit(bx, by, eidx, etyp);
    run_frame(bx, by, hit, lat, typ, idx);
    elat = (eidx >= 0) ? eidx + 2 : N + 1;
    if (eidx >= 0) begin
      m_alive[eidx] = 0;
      m_score = (m_score + 1 > 511) ? 511 : m_score + 1;
    end
    tests_run++;
    if (hit !== (eidx >= 0) || lat != elat ||
        (hit && (typ !== etyp || idx != eidx))) begin
      fails++;
      $display("FAIL %s ball(%0d,%0d): hit=%0d lat=%0d typ=%b idx=%0d want hit=%0d lat=%0d typ=%b idx=%0d",
               nm, bx, by, hit, lat, typ, idx, eidx >= 0, elat, etyp, eidx);
    end
    tests_run++;
    if (o_alive !== m_alive || o_score !== 9'(m_score)) begin
      fails++;
      $display("FAIL %s state: alive=%h score=%0d want alive=%h score=%0d",
               nm, o_alive, o_score, m_alive, m_score);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    m_alive = '1; m_score = 0; m_over = 0;
    @(negedge clk);
    tests_run++;
    if (o_alive !== '1 || o_score !== 0 || o_hit_valid !== 0 ||
        o_hit_type !== 0 || o_hit_idx !== 0 || o_endgame !== 0 ||
        o_overrun !== 0 || o_busy !== 0) begin
      fails++;
      $display("FAIL reset: alive=%h score=%0d v=%b t=%b i=%0d eg=%b ov=%b busy=%b want ones/0",
               o_alive, o_score, o_hit_valid, o_hit_type, o_hit_idx,
               o_endgame, o_overrun, o_busy);
    end
  endtask

  task automatic test_basic();
    @(negedge clk);
    i_animate = 0; i_ani_stb = 1;
    @(negedge clk);
    i_ani_stb = 0;
    tests_run++;
    if (o_busy !== 0) begin
      fails++;
      $display("FAIL no_animate: busy=%b want 0", o_busy);
    end
    frame_check("top_bottom", 40, 35);
    do_ack();
    tests_run++;
    if (o_hit_valid !== 0 || o_busy !== 0) begin
      fails++;
      $display("FAIL ack_drop: valid=%b busy=%b want 0 0", o_hit_valid, o_busy);
    end
    do_start();
    frame_check("left_right", 80, 20);
    do_ack();
    do_start();
    frame_check("corner", 80, 35);
    do_ack();
    do_start();
    frame_check("lowest_idx", 75, 35);
    do_ack();
    frame_check("next_idx", 75, 35);
    do_ack();
  endtask

  task automatic test_hold_ack();
    bit ok = 1;
    do_start();
    frame_check("hold_hit", 40, 35);
    for (int c = 0; c < 50; c++) begin
      if (c == 10) i_ani_stb = 1;
      @(negedge clk);
      i_ani_stb = 0;
      if (o_hit_valid !== 1 || o_hit_type !== 2'b01 || o_hit_idx !== 0)
        ok = 0;
    end
    tests_run++;
    if (!ok) begin
      fails++;
      $display("FAIL hold_stable: valid=%b type=%b idx=%0d want 1 01 0",
               o_hit_valid, o_hit_type, o_hit_idx);
    end
    tests_run++;
    if (o_overrun !== 1) begin
      fails++;
      $display("FAIL overrun_set: overrun=%b want 1", o_overrun);
    end
    do_ack();
    tests_run++;
    if (o_hit_valid !== 0 || o_overrun !== 1) begin
      fails++;
      $display("FAIL hold_ack: valid=%b overrun=%b want 0 1", o_hit_valid, o_overrun);
    end
  endtask

  task automatic test_endgame();
    do_start();
    for (int i = 0; i < N; i++) begin
      frame_check("clear", bcx(i), bcy(i) + F);
      do_ack();
    end
    tests_run++;
    if (o_endgame !== 1 || o_score !== 9'd32 || o_alive !== 0) begin
      fails++;
      $display("FAIL endgame: eg=%b score=%0d alive=%h want 1 32 0",
               o_endgame, o_score, o_alive);
    end
    @(negedge clk);
    i_ball_x = 40; i_ball_y = 35; i_ani_stb = 1;
    @(negedge clk);
    i_ani_stb = 0;
    repeat (5) @(negedge clk);
    tests_run++;
    if (o_endgame !== 1 || o_hit_valid !== 0 || o_score !== 9'd32) begin
      fails++;
      $display("FAIL done_ignore: eg=%b valid=%b score=%0d want 1 0 32",
               o_endgame, o_hit_valid, o_score);
    end
    @(negedge clk);
    i_start = 1; i_ani_stb = 1;
    @(negedge clk);
    i_start = 0; i_ani_stb = 0;
    m_alive = '1; m_score = 0;
    tests_run++;
    if (o_endgame !== 0 || o_alive !== '1 || o_score !== 0 ||
        o_overrun !== 0 || o_busy !== 0) begin
      fails++;
      $display("FAIL restart: eg=%b alive=%h score=%0d ov=%b busy=%b want 0 ones 0 0 0",
               o_endgame, o_alive, o_score, o_overrun, o_busy);
    end
  endtask

  task automatic test_reset_midscan();
    bit hit; int lat, idx; logic [1:0] typ;
    do_start();
    frame_check("pre_rst", 40, 35);
    do_ack();
    @(negedge clk);
    i_ball_x = 2000; i_ball_y = 2000; i_ani_stb = 1;
    @(negedge clk);
    i_ani_stb = 0;
    repeat (5) @(negedge clk);
    tests_run++;
    if (o_busy !== 1) begin
      fails++;
      $display("FAIL midscan_busy: busy=%b want 1", o_busy);
    end
    #2 rst_n = 0;
    #1;
    tests_run++;
    if (o_alive !== '1 || o_score !== 0 || o_busy !== 0 ||
        o_hit_valid !== 0 || o_hit_idx !== 0 || o_hit_type !== 0) begin
      fails++;
      $display("FAIL async_rst: alive=%h score=%0d busy=%b v=%b want ones 0 0 0",
               o_alive, o_score, o_busy, o_hit_valid);
    end
    @(negedge clk);
    rst_n = 1;
    m_alive = '1; m_score = 0;
    run_frame(40, 35, hit, lat, typ, idx);
    @(negedge clk);
    i_start = 1;
    @(negedge clk);
    i_start = 0;
    tests_run++;
    if (!hit || o_hit_valid !== 0 || o_alive !== '1 || o_score !== 0) begin
      fails++;
      $display("FAIL start_in_hit: hit=%0d valid=%b alive=%h score=%0d want 1 0 ones 0",
               hit, o_hit_valid, o_alive, o_score);
    end
  endtask

  task automatic test_random();
    do_start();
    for (int n = 0; n < 60; n++) begin
      int i, bx, by, k;
      i = $urandom_range(0, N - 1);
      k = $urandom_range(0, 3);
      bx = bcx(i); by = bcy(i);
      unique case (k)
        0: begin
          bx += $urandom_range(0, 1) ? E : -E;
          by += int'($urandom_range(0, 2 * F + 4)) - F - 2;
        end
        1: begin
          by += $urandom_range(0, 1) ? F : -F;
          bx += int'($urandom_range(0, 2 * E + 6)) - E - 3;
        end
        2: begin
          bx += $urandom_range(0, 1) ? E : -E;
          by += $urandom_range(0, 1) ? F : -F;
        end
        default: begin
          bx = $urandom_range(0, 640);
          by = $urandom_range(0, 120);
        end
      endcase
      if (bx < 0) bx = 0;
      if (by < 0) by = 0;
      frame_check("random", bx, by);
      if (o_hit_valid) do_ack();
      if (o_endgame) do_start();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold_ack();
    test_endgame();
    test_reset_midscan();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
